// File: rtl/stack_node.sv
// LIFO stack node on the core grid: neighbour pushes with fixed L>R>U>D priority,
// and the top word is offered round-robin to one side at a time through rready/read.
module stack_node #(
    parameter int DEPTH = 15,
    parameter int WIDTH = 11
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [3:0]                 wreq,
    input  logic signed [WIDTH-1:0]    in_l,
    input  logic signed [WIDTH-1:0]    in_r,
    input  logic signed [WIDTH-1:0]    in_u,
    input  logic signed [WIDTH-1:0]    in_d,
    output logic [3:0]                 wready,
    output logic [3:0]                 rready,
    output logic signed [WIDTH-1:0]    rdata,
    input  logic [3:0]                 read,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {IDLE, OFFER, CHECK} state_t;

    state_t                  state, state_next;
    logic [1:0]              grant;
    logic signed [WIDTH-1:0] mem [DEPTH];

    logic                    push_en;
    logic [1:0]              push_side;
    logic signed [WIDTH-1:0] push_data;
    logic                    pop_en;
    logic [CW-1:0]           wr_idx;
    logic [CW-1:0]           count_next;
    logic signed [WIDTH-1:0] top_next;

    // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latches).
    always_comb begin
        push_en   = 1'b0;
        push_side = 2'd0;
        // Scanning from D down to L lets the lowest eligible index win.
        for (int i = 3; i >= 0; i--) begin
            if (wreq[i] && !wready[i] && count < CW'(DEPTH) && state != OFFER) begin
                push_en   = 1'b1;
                push_side = 2'(i);
            end
        end

        case (push_side)
            2'd0:    push_data = in_l;
            2'd1:    push_data = in_r;
            2'd2:    push_data = in_u;
            default: push_data = in_d;
        endcase

        pop_en     = (state == CHECK) && read[grant];
        // Pop happens before push, so a same-cycle push overwrites the freed top slot.
        wr_idx     = count - CW'(pop_en);
        count_next = wr_idx + CW'(push_en);

        if (push_en)
            top_next = push_data;
        else if (count_next == '0)
            top_next = '0;
        else
            top_next = mem[count_next - 1'b1];

        state_next = state;
        case (state)
            IDLE:    state_next = (count != '0) ? OFFER : IDLE;
            OFFER:   state_next = CHECK;
            CHECK:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            grant  <= 2'd0;
            count  <= '0;
            wready <= 4'b0000;
            rready <= 4'b0000;
            rdata  <= '0;
        end else begin
            state  <= state_next;
            count  <= count_next;
            rdata  <= top_next;
            wready <= push_en ? (4'b0001 << push_side) : 4'b0000;
            rready <= (state == IDLE && count != '0) ? (4'b0001 << grant) : 4'b0000;
            if (state == CHECK)
                grant <= grant + 2'd1;
        end
    end

    // NOTE: storage is not reset; count alone defines which words are valid.
    always_ff @(posedge clk) begin
        if (!rst && push_en)
            mem[wr_idx] <= push_data;
    end
endmodule

// File: tb/tb_stack_node.sv
// Randomized scoreboard bench for stack_node: a queue-based stack model predicts
// per-cycle outputs, and a separate monitor compares them one cycle later.
module tb_stack_node;
    localparam int DEPTH = 15;
    localparam int WIDTH = 11;
    localparam int CW    = $clog2(DEPTH+1);

    logic                    clk = 1'b0;
    logic                    rst;
    logic [3:0]              wreq, read;
    logic signed [WIDTH-1:0] in_l, in_r, in_u, in_d;
    logic [3:0]              wready, rready;
    logic signed [WIDTH-1:0] rdata;
    logic [CW-1:0]           count;

    always #5 clk = ~clk;

    stack_node #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .wreq(wreq),
        .in_l(in_l), .in_r(in_r), .in_u(in_u), .in_d(in_d),
        .wready(wready), .rready(rready), .rdata(rdata),
        .read(read), .count(count)
    );

    typedef struct {
        logic [CW-1:0]           count;
        logic [3:0]              wready;
        logic [3:0]              rready;
        logic signed [WIDTH-1:0] rdata;
        bit                      chk_rdata;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: a plain queue used as a stack plus a 3-phase round-robin offer cycle.
    int                      phase;    // 0 idle, 1 offering, 2 awaiting read strobe
    int                      grant_m;
    logic signed [WIDTH-1:0] stk[$];
    logic [3:0]              ack_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic model_step();
        exp_t e;
        int   side, sz;
        e.rready = 4'b0000;
        if (rst) begin
            phase = 0; grant_m = 0; stk.delete(); ack_m = 4'b0000;
        end else begin
            sz   = stk.size();
            side = -1;
            for (int i = 0; i < 4; i++)
                if (side < 0 && wreq[i] && !ack_m[i] && sz < DEPTH && phase != 1) side = i;
            if (phase == 2 && read[grant_m]) void'(stk.pop_back());
            if (side >= 0)
                stk.push_back(side == 0 ? in_l : side == 1 ? in_r : side == 2 ? in_u : in_d);
            ack_m = (side >= 0) ? 4'(1 << side) : 4'b0000;
            case (phase)
                0: if (sz > 0) begin phase = 1; e.rready = 4'(1 << grant_m); end
                1: phase = 2;
                default: begin phase = 0; grant_m = (grant_m + 1) % 4; end
            endcase
        end
        e.wready    = ack_m;
        e.count     = CW'(stk.size());
        e.rdata     = (stk.size() > 0) ? stk[$] : '0;
        e.chk_rdata = (e.rready != 0) || (stk.size() == 0);
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic r, input logic [3:0] wq, input logic [3:0] rd,
                         input logic signed [WIDTH-1:0] l, input logic signed [WIDTH-1:0] rr,
                         input logic signed [WIDTH-1:0] u, input logic signed [WIDTH-1:0] d);
        @(negedge clk);
        rst = r; wreq = wq; read = rd;
        in_l = l; in_r = rr; in_u = u; in_d = d;
        model_step();
    endtask

    // Monitor: the expectation pushed before an edge is compared just after it.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("count",  32'(count),  32'(e.count));
            check("wready", 32'(wready), 32'(e.wready));
            check("rready", 32'(rready), 32'(e.rready));
            if (e.chk_rdata) check("rdata", 32'(rdata), 32'(e.rdata));
        end
    end

    initial begin
        rst = 1'b1; wreq = '0; read = '0; in_l = '0; in_r = '0; in_u = '0; in_d = '0;
        phase = 0; grant_m = 0; ack_m = '0;

        // Reset while every side requests a write.
        repeat (3) drive(1'b1, 4'hF, 4'h0, 11'sd1, 11'sd2, 11'sd3, 11'sd4);
        // Single held write from L, then idle offers rotating with no reads.
        repeat (3)  drive(1'b0, 4'b0001, 4'h0, 11'sd5, 11'sd0, 11'sd0, 11'sd0);
        repeat (14) drive(1'b0, 4'b0000, 4'h0, 11'sd0, 11'sd0, 11'sd0, 11'sd0);
        // Fill to full from L, then D waits with -9 until a pop frees a slot.
        for (int i = 0; i < 40; i++)
            drive(1'b0, 4'b0001, 4'h0, 11'(100 + i), 11'sd0, 11'sd0, 11'sd0);
        repeat (10) drive(1'b0, 4'b1000, 4'h0, 11'sd0, 11'sd0, 11'sd0, -11'sd9);
        repeat (4)  drive(1'b0, 4'b1000, 4'hF, 11'sd0, 11'sd0, 11'sd0, -11'sd9);
        repeat (4)  drive(1'b0, 4'b0000, 4'h0, 11'sd0, 11'sd0, 11'sd0, 11'sd0);
        // Drain, then L and D requesting together with reads on every side.
        repeat (60) drive(1'b0, 4'b0000, 4'hF, 11'sd0, 11'sd0, 11'sd0, 11'sd0);
        repeat (12) drive(1'b0, 4'b1001, 4'hF, 11'sd21, 11'sd0, 11'sd0, -11'sd22);

        // Randomized traffic with occasional resets; the bias varies fill level over time.
        for (int i = 0; i < 4000; i++) begin
            logic [3:0] wq, rd;
            int bias;
            bias = ((i / 500) % 2 == 0) ? 3 : 1;
            for (int s = 0; s < 4; s++) begin
                wq[s] = ($urandom_range(0, 3) < bias);
                rd[s] = ($urandom_range(0, 3) >= bias);
            end
            drive($urandom_range(0, 299) == 0, wq, rd,
                  11'($urandom), 11'($urandom), 11'($urandom), 11'($urandom));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
